// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter of per-channel command FIFOs onto one memory port
module mem_port_arbiter #(
    parameter int  CHANNELS = 2,
    parameter int  ADDR_W   = 22,
    parameter int  DATA_W   = 16,
    parameter int  DEPTH    = 8,
    parameter int  RD_LAT   = 2,
    localparam int MW       = DATA_W / 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       MemClk,
    input  logic                       Reset,
    input  logic [CHANNELS-1:0]        ch_Valid,
    output logic [CHANNELS-1:0]        ch_Ready,
    input  logic [CHANNELS-1:0]        ch_Read,
    input  logic [CHANNELS*ADDR_W-1:0] ch_Address,
    input  logic [CHANNELS*MW-1:0]     ch_DQmask,
    input  logic [CHANNELS*DATA_W-1:0] ch_DataWrite,
    input  logic                       P0_Ready,
    output logic                       P0_Valid,
    output logic                       P0_Read,
    output logic [ADDR_W-1:0]          P0_Address,
    output logic [MW-1:0]              P0_DQmask,
    output logic [DATA_W-1:0]          P0_DataWrite,
    input  logic [DATA_W-1:0]          P0_DataRead,
    output logic                       rsp_Valid,
    output logic [CH_W-1:0]            rsp_Channel,
    output logic [DATA_W-1:0]          rsp_Data
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + ADDR_W + MW + DATA_W;

    logic [EW-1:0]       fifo_mem [CHANNELS][DEPTH];
    logic [AW:0]         wr_ptr   [CHANNELS];
    logic [AW:0]         rd_ptr   [CHANNELS];
    logic [EW-1:0]       entry_in [CHANNELS];
    logic [CHANNELS-1:0] empty, full, push, pop;

    logic [CH_W-1:0]     rr_ptr, grant_ch, cur_ch, next_ptr;
    logic [CH_W:0]       cand;
    logic                grant_any, load_en;
    logic [EW-1:0]       head;

    logic [RD_LAT-1:0]   pipe_v;
    logic [CH_W-1:0]     pipe_ch [RD_LAT];

    always_comb begin
        empty = '0;
        full  = '0;
        push  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            empty[i]    = (wr_ptr[i] == rd_ptr[i]);
            full[i]     = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                          (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            push[i]     = ch_Valid[i] && !full[i];
            entry_in[i] = {ch_Read[i], ch_Address[i*ADDR_W +: ADDR_W],
                           ch_DQmask[i*MW +: MW], ch_DataWrite[i*DATA_W +: DATA_W]};
        end
    end

    assign ch_Ready = ~full;

    // Search starts at rr_ptr, the channel after the last grant.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(CHANNELS)) begin
                cand = cand - (CH_W+1)'(CHANNELS);
            end
            if (!grant_any && !empty[cand[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_ch  = cand[CH_W-1:0];
            end
        end
    end

    assign load_en  = !P0_Valid || P0_Ready;
    assign head     = fifo_mem[grant_ch][rd_ptr[grant_ch][AW-1:0]];
    assign next_ptr = (grant_ch == CH_W'(CHANNELS - 1)) ? '0 : grant_ch + CH_W'(1);

    always_comb begin
        pop = '0;
        if (load_en && grant_any) begin
            pop[grant_ch] = 1'b1;
        end
    end

    always_ff @(posedge MemClk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge MemClk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr[i][AW-1:0]] <= entry_in[i];
        end
    end

    // The P0 register reloads in the issue cycle itself, giving one command per cycle.
    always_ff @(posedge MemClk or negedge Reset) begin
        if (!Reset) begin
            P0_Valid     <= 1'b0;
            P0_Read      <= 1'b0;
            P0_Address   <= '0;
            P0_DQmask    <= '1;
            P0_DataWrite <= '0;
            cur_ch       <= '0;
            rr_ptr       <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                P0_Valid     <= 1'b1;
                P0_Read      <= head[EW-1];
                P0_Address   <= head[EW-2 -: ADDR_W];
                P0_DQmask    <= head[EW-1] ? '1 : head[DATA_W +: MW];
                P0_DataWrite <= head[DATA_W-1:0];
                cur_ch       <= grant_ch;
                rr_ptr       <= next_ptr;
            end else begin
                P0_Valid  <= 1'b0;
                P0_Read   <= 1'b0;
                P0_DQmask <= '1;
            end
        end
    end

    always_ff @(posedge MemClk or negedge Reset) begin
        if (!Reset) begin
            pipe_v      <= '0;
            for (int k = 0; k < RD_LAT; k++) pipe_ch[k] <= '0;
            rsp_Valid   <= 1'b0;
            rsp_Channel <= '0;
            rsp_Data    <= '0;
        end else begin
            pipe_v[0]  <= P0_Valid && P0_Ready && P0_Read;
            pipe_ch[0] <= cur_ch;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_ch[k] <= pipe_ch[k-1];
            end
            rsp_Valid <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) begin
                rsp_Channel <= pipe_ch[RD_LAT-1];
                rsp_Data    <= P0_DataRead;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int CHANNELS = 2;
    localparam int ADDR_W   = 22;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 8;
    localparam int RD_LAT   = 2;
    localparam int MW       = DATA_W / 8;

    logic                       MemClk = 1'b0;
    logic                       Reset  = 1'b1;
    logic [CHANNELS-1:0]        ch_Valid = '0;
    logic [CHANNELS-1:0]        ch_Ready;
    logic [CHANNELS-1:0]        ch_Read = '0;
    logic [CHANNELS*ADDR_W-1:0] ch_Address = '0;
    logic [CHANNELS*MW-1:0]     ch_DQmask = '0;
    logic [CHANNELS*DATA_W-1:0] ch_DataWrite = '0;
    logic                       P0_Ready = 1'b0;
    logic                       P0_Valid, P0_Read;
    logic [ADDR_W-1:0]          P0_Address;
    logic [MW-1:0]              P0_DQmask;
    logic [DATA_W-1:0]          P0_DataWrite;
    logic [DATA_W-1:0]          P0_DataRead = '0;
    logic                       rsp_Valid;
    logic [0:0]                 rsp_Channel;
    logic [DATA_W-1:0]          rsp_Data;

    mem_port_arbiter #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .MemClk(MemClk), .Reset(Reset), .ch_Valid(ch_Valid), .ch_Ready(ch_Ready),
        .ch_Read(ch_Read), .ch_Address(ch_Address), .ch_DQmask(ch_DQmask),
        .ch_DataWrite(ch_DataWrite), .P0_Ready(P0_Ready), .P0_Valid(P0_Valid),
        .P0_Read(P0_Read), .P0_Address(P0_Address), .P0_DQmask(P0_DQmask),
        .P0_DataWrite(P0_DataWrite), .P0_DataRead(P0_DataRead), .rsp_Valid(rsp_Valid),
        .rsp_Channel(rsp_Channel), .rsp_Data(rsp_Data));

    always #5 MemClk = ~MemClk;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [MW-1:0]     mask;
        logic [DATA_W-1:0] data;
        logic              ch;
    } cmd_t;
    typedef struct {
        logic              ch;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    cmd_t exp_q[$];
    rsp_t rsp_q[$];
    int   n_cmp = 0, n_bad = 0, n_issued = 0, cyc = 0;
    logic              dl_v [RD_LAT+1];
    logic [DATA_W-1:0] dl_d [RD_LAT+1];

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hEDCB;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic rd, input logic [ADDR_W-1:0] addr,
                         input logic [MW-1:0] mask, input logic [DATA_W-1:0] data);
        ch_Valid[ch]                     = 1'b1;
        ch_Read[ch]                      = rd;
        ch_Address[ch*ADDR_W +: ADDR_W]  = addr;
        ch_DQmask[ch*MW +: MW]           = mask;
        ch_DataWrite[ch*DATA_W +: DATA_W] = data;
    endtask

    task automatic expect_cmd(input int ch, input logic rd, input logic [ADDR_W-1:0] addr,
                              input logic [MW-1:0] mask, input logic [DATA_W-1:0] data);
        exp_q.push_back('{rd: rd, addr: addr, mask: mask, data: data, ch: ch[0]});
    endtask

    // Idle channels carry random payload that must never be enqueued.
    task automatic clear_inputs();
        ch_Valid     = '0;
        ch_Read      = CHANNELS'($urandom());
        ch_Address   = (CHANNELS*ADDR_W)'({$urandom(), $urandom()});
        ch_DQmask    = (CHANNELS*MW)'($urandom());
        ch_DataWrite = (CHANNELS*DATA_W)'($urandom());
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && rsp_q.size() == 0) break;
            @(negedge MemClk); #1;
        end
        check({tag, "_drained"}, exp_q.size() + rsp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_p0_valid"}, P0_Valid, 0);
        check({tag, "_p0_read"}, P0_Read, 0);
        check({tag, "_p0_addr"}, P0_Address, 0);
        check({tag, "_p0_mask"}, P0_DQmask, 2'b11);
        check({tag, "_p0_wdata"}, P0_DataWrite, 0);
        check({tag, "_rsp_valid"}, rsp_Valid, 0);
        check({tag, "_rsp_ch"}, rsp_Channel, 0);
        check({tag, "_rsp_data"}, rsp_Data, 0);
        check({tag, "_ch_ready"}, ch_Ready, 2'b11);
    endtask

    always @(posedge MemClk) cyc++;

    // Memory model plus scoreboard checks, sampled mid-cycle.
    always @(negedge MemClk) begin : monitor
        cmd_t e;
        rsp_t r;
        logic exp_v;
        for (int k = RD_LAT; k > 0; k--) begin
            dl_v[k] = dl_v[k-1];
            dl_d[k] = dl_d[k-1];
        end
        dl_v[0] = P0_Valid && P0_Ready && P0_Read;
        dl_d[0] = mem_data(P0_Address);
        P0_DataRead = (dl_v[RD_LAT] === 1'b1) ? dl_d[RD_LAT] : 16'hDEAD;
        if (Reset) begin
            if (P0_Valid && P0_Ready) begin
                n_issued++;
                check("issue_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("issue_read", P0_Read, e.rd);
                    check("issue_addr", P0_Address, e.addr);
                    check("issue_mask", P0_DQmask, e.rd ? 2'b11 : e.mask);
                    if (!e.rd) check("issue_wdata", P0_DataWrite, e.data);
                    if (e.rd) rsp_q.push_back('{ch: e.ch, data: mem_data(e.addr), due: cyc + RD_LAT + 1});
                end
            end
            if (!P0_Valid) check("idle_mask", P0_DQmask, 2'b11);
            while (rsp_q.size() != 0 && rsp_q[0].due < cyc) void'(rsp_q.pop_front());
            exp_v = 1'b0;
            if (rsp_q.size() != 0) exp_v = (rsp_q[0].due == cyc);
            check("rsp_valid", rsp_Valid, exp_v);
            if (exp_v) begin
                r = rsp_q.pop_front();
                check("rsp_channel", rsp_Channel, r.ch);
                check("rsp_data", rsp_Data, r.data);
            end
        end
    end

    initial begin
        int n0;
        for (int k = 0; k <= RD_LAT; k++) begin
            dl_v[k] = 1'b0;
            dl_d[k] = '0;
        end
        #1 Reset = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(posedge MemClk);
        #1 Reset = 1'b1;

        // Single write on ch0
        @(posedge MemClk); #1;
        P0_Ready = 1'b1;
        drive(0, 1'b0, 22'h000010, 2'b00, 16'hBEEF);
        expect_cmd(0, 1'b0, 22'h000010, 2'b00, 16'hBEEF);
        @(posedge MemClk); #1;
        clear_inputs();
        @(posedge MemClk);
        @(negedge MemClk);
        check("write_valid_next_cycle", P0_Valid, 1);
        @(negedge MemClk);
        check("write_valid_drops", P0_Valid, 0);
        wait_drain("write");

        // Single read on ch1 at top address
        @(posedge MemClk); #1;
        drive(1, 1'b1, 22'h3FFFFF, 2'b00, 16'h5555);
        expect_cmd(1, 1'b1, 22'h3FFFFF, 2'b11, 16'h0);
        @(posedge MemClk); #1;
        clear_inputs();
        wait_drain("read");

        // Both channels loaded while port stalled, then released
        @(posedge MemClk); #1;
        P0_Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, 22'h000100 + 22'(k), 2'(k), 16'h1000 + 16'(k));
            drive(1, 1'b1, 22'h000200 + 22'(k), 2'b00, 16'h0);
            @(posedge MemClk); #1;
        end
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            expect_cmd(0, 1'b0, 22'h000100 + 22'(k), 2'(k), 16'h1000 + 16'(k));
            expect_cmd(1, 1'b1, 22'h000200 + 22'(k), 2'b11, 16'h0);
        end
        @(posedge MemClk); #1;
        n0 = n_issued;
        P0_Ready = 1'b1;
        repeat (6) @(negedge MemClk);
        #1 check("rr_six_consecutive", n_issued - n0, 6);
        @(negedge MemClk);
        #1 check("rr_then_idle", P0_Valid, 0);
        wait_drain("rr");

        // Fill ch0: eight FIFO entries plus one in the P0 register
        @(posedge MemClk); #1;
        P0_Ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("fill_ready", ch_Ready[0], 1);
            drive(0, (k % 2 == 1) || (k >= 6), 22'h000300 + 22'(k), 2'(k), 16'h3000 + 16'(k));
            expect_cmd(0, (k % 2 == 1) || (k >= 6), 22'h000300 + 22'(k), 2'(k), 16'h3000 + 16'(k));
            @(posedge MemClk); #1;
        end
        check("full_ready", ch_Ready, 2'b10);
        drive(0, 1'b0, 22'h0ABCDE, 2'b01, 16'hBAD0);
        @(posedge MemClk); #1;
        check("full_rejects", ch_Ready, 2'b10);
        P0_Ready = 1'b1;
        @(posedge MemClk); #1;
        clear_inputs();
        check("full_deq_no_enq", ch_Ready[0], 1);
        wait_drain("fill");

        // Reset between a read issue and its response
        @(posedge MemClk); #1;
        P0_Ready = 1'b0;
        drive(1, 1'b1, 22'h000555, 2'b00, 16'h0);
        drive(0, 1'b0, 22'h000666, 2'b10, 16'h6666);
        expect_cmd(1, 1'b1, 22'h000555, 2'b11, 16'h0);
        @(posedge MemClk); #1;
        clear_inputs();
        @(posedge MemClk); #1;
        n0 = n_issued;
        P0_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge MemClk); #1;
            if (n_issued != n0) break;
        end
        check("pre_reset_issued", n_issued - n0, 1);
        @(posedge MemClk); #1;
        P0_Ready = 1'b0;
        check("pre_reset_p0_valid", P0_Valid, 1);
        Reset = 1'b0;
        rsp_q.delete();
        exp_q.delete();
        #1 check_reset("midreset");
        repeat (2) @(posedge MemClk);
        #1 Reset = 1'b1;
        P0_Ready = 1'b1;
        repeat (8) @(negedge MemClk);
        #1 check("post_reset_idle", P0_Valid, 0);
        check("post_reset_ready", ch_Ready, 2'b11);
        check("final_queues", exp_q.size() + rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning number of requester channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 22, meaning word address width.
REQ-003 SHALL have parameter DATA_W, default 16, meaning data width; mask width fixed at DATA_W/8.
REQ-004 SHALL have parameter DEPTH, default 8, meaning per-channel command FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameter RD_LAT, default 2, meaning cycles from read issue to valid P0_DataRead (>=1).
REQ-006 SHALL have port MemClk  input  1  sole clock, all logic on posedge.
REQ-007 SHALL have port Reset  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port ch_Valid  input  CHANNELS  per-channel command present.
REQ-009 SHALL have port ch_Ready  output  CHANNELS  per-channel FIFO not full.
REQ-010 SHALL have port ch_Read  input  CHANNELS  per-channel command is a read.
REQ-011 SHALL have port ch_Address  input  CHANNELS*ADDR_W  packed addresses, channel 0 in LSBs.
REQ-012 SHALL have port ch_DQmask  input  CHANNELS*DATA_W/8  packed byte masks, 1 = byte not written.
REQ-013 SHALL have port ch_DataWrite  input  CHANNELS*DATA_W  packed write data.
REQ-014 SHALL have port P0_Ready  input  1  memory port accepts a command this cycle.
REQ-015 SHALL have port P0_Valid  output  1  command presented on P0.
REQ-016 SHALL have port P0_Read  output  1  presented command is a read.
REQ-017 SHALL have port P0_Address  output  ADDR_W  command address.
REQ-018 SHALL have port P0_DQmask  output  DATA_W/8  byte mask; all ones when P0_Valid=0 or P0_Read=1.
REQ-019 SHALL have port P0_DataWrite  output  DATA_W  write data.
REQ-020 SHALL have port P0_DataRead  input  DATA_W  read data, valid RD_LAT cycles after read issue.
REQ-021 SHALL have port rsp_Valid  output  1  read response strobe, one cycle.
REQ-022 SHALL have port rsp_Channel  output  clog2(CHANNELS) (min 1)  channel owning the response.
REQ-023 SHALL have port rsp_Data  output  DATA_W  registered read data.

Function
REQ-024 SHALL enqueue a command into channel i FIFO on a posedge where ch_Valid[i]=1 and ch_Ready[i]=1; ch_Ready[i]=0 exactly when FIFO i holds DEPTH entries.
REQ-025 SHALL drive P0_* from registers; a command is issued on a posedge where P0_Valid=1 and P0_Ready=1.
REQ-026 SHALL hold all P0_* outputs stable while P0_Valid=1 and P0_Ready=0.
REQ-027 SHALL select the next command by round-robin starting at the channel after the last granted one, skipping empty FIFOs; after reset, search starts at channel 0.
REQ-028 SHALL load a new command into the P0 register in the issue cycle itself when any FIFO is non-empty, sustaining one command per cycle with P0_Ready=1 continuously.
REQ-029 SHALL make an enqueue into an empty FIFO visible to arbitration on the cycle after the enqueue (1-cycle input-to-P0_Valid latency minimum).
REQ-030 SHALL support simultaneous enqueue and dequeue on the same FIFO when full: ch_Ready stays 0 that cycle, occupancy unchanged.
REQ-031 SHALL track each issued read in a RD_LAT-stage shift pipeline of {valid, channel}; stage RD_LAT captures P0_DataRead into rsp_Data and asserts rsp_Valid for one cycle with the matching rsp_Channel.
REQ-032 SHALL never throttle responses; responses leave in issue order, back-to-back reads yield back-to-back rsp_Valid.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH using an extra wrap bit for full/empty distinction.
REQ-034 SHALL ignore ch_Read, ch_Address, ch_DQmask, ch_DataWrite when ch_Valid=0.

Reset
REQ-035 SHALL, on Reset=0, asynchronously empty all FIFOs, clear the read pipeline, set P0_Valid=0, P0_Read=0, P0_Address=0, P0_DQmask=all ones, P0_DataWrite=0, rsp_Valid=0, rsp_Channel=0, rsp_Data=0, round-robin pointer to channel 0, ch_Ready all ones.
REQ-036 SHALL discard in-flight reads when Reset asserts mid-operation; no rsp_Valid for them after release.

Verification
REQ-037 Single write ch0 addr 0x000010 mask 00 data 0xBEEF, P0_Ready=1 -> P0_Valid=1 next cycle with those values, P0_Read=0, then P0_Valid=0.
REQ-038 Read ch1 addr 0x3FFFFF, P0_DataRead=0x1234 at RD_LAT=2 -> rsp_Valid one cycle, rsp_Channel=1, rsp_Data=0x1234, P0_DQmask=11 during issue.
REQ-039 Both channels hold 3 commands each, P0_Ready=1 -> issue order ch0,ch1,ch0,ch1,ch0,ch1 in 6 consecutive cycles.
REQ-040 P0_Ready=0, push 9 commands into ch0 (DEPTH 8) -> ch_Ready[0]=0 after 8 FIFO entries plus 1 in P0 register, 9th held; release P0_Ready -> all 9 issued in order.
REQ-041 Reset=0 pulse between read issue and its response -> all outputs at reset values immediately, no rsp_Valid afterwards.
